// File: rtl/fir_n_multicycle.sv
// fir_n_multicycle: time-multiplexed N-tap FIR on signed Q1.(WIDTH-1) samples.
// One shared multiplier and one shared adder walk the taps, one tap per clock,
// so each output sample takes N cycles. The phase counter p selects the tap.
//
// Build option: define FIR_SATURATE_EN to make the product and every partial
// sum saturate to [-1, 1-2^-(WIDTH-1)] instead of wrapping. Without it all
// arithmetic is plain two's-complement wrap-around.
//
// Input contract: x is sampled only on the clock edge that ends a frame
// (p == N-1); it must be stable through that last phase. Values of x during
// the other phases are ignored.
module fir_n_multicycle #(
    parameter int                    WIDTH  = 16,
    parameter int                    N      = 2,
    parameter logic [N*WIDTH-1:0]    COEFFS = {16'h2AAA, 16'h2AAA}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] mul_out_show,
    output logic [WIDTH-1:0] add_out_show
);

    // Phase counter width; at least one bit even for degenerate sizes.
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(N - 1);

    // Saturation limits in Q1.(WIDTH-1).
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef FIR_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]    p;
    logic [WIDTH-1:0] sd [N];
    logic [WIDTH-1:0] acc;

    // Coefficient table unpacked from the packed parameter; h[0] in the LSBs.
    logic [WIDTH-1:0] h [N];

    for (genvar k = 0; k < N; k++) begin : g_coeff
        assign h[k] = COEFFS[k*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]          sd_sel;
    logic [WIDTH-1:0]          h_sel;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] prod_sh;
    logic                      mul_ovf;
    logic [WIDTH-1:0]          mul_out;
    logic [WIDTH-1:0]          acc_in;
    logic [WIDTH:0]            sum_ext;
    logic                      add_ovf;
    logic [WIDTH-1:0]          add_out;

    // Shared multiplier: full signed product, rescaled by an arithmetic shift
    // of WIDTH-1 (truncation toward minus infinity). The result only fits in
    // WIDTH bits when every bit from 2*WIDTH-1 down to WIDTH-1 of the shifted
    // product agrees; in practice only -1 * -1 breaks that.
    always_comb begin
        sd_sel  = sd[p];
        h_sel   = h[p];
        prod    = $signed({{WIDTH{sd_sel[WIDTH-1]}}, sd_sel})
                * $signed({{WIDTH{h_sel[WIDTH-1]}},  h_sel});
        prod_sh = prod >>> (WIDTH - 1);
        mul_ovf = !((&prod_sh[2*WIDTH-1:WIDTH-1]) || !(|prod_sh[2*WIDTH-1:WIDTH-1]));
        mul_out = prod_sh[WIDTH-1:0];
        if (SAT_EN && mul_ovf) begin
            mul_out = prod_sh[2*WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Shared adder: the first tap of a frame starts from zero rather than the
    // accumulator, so a frame never depends on the previous frame's sum.
    // Overflow is a disagreement between the carry-out sign and result sign.
    always_comb begin
        acc_in  = (p == '0) ? '0 : acc;
        sum_ext = {acc_in[WIDTH-1], acc_in} + {mul_out[WIDTH-1], mul_out};
        add_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
        add_out = sum_ext[WIDTH-1:0];
        if (SAT_EN && add_ovf) begin
            add_out = sum_ext[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    // Debug taps simply mirror the live multiplier and adder results.
    always_comb begin
        mul_out_show = mul_out;
        add_out_show = add_out;
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Phase counter, accumulator, output register and delay line. At the
    // frame-end edge the finished sum goes to y, the accumulator is cleared
    // and the delay line shifts in the new sample, all on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            p   <= '0;
            acc <= '0;
            y   <= '0;
            for (int k = 0; k < N; k++) begin
                sd[k] <= '0;
            end
        end else begin
            if (p == P_LAST) begin
                p     <= '0;
                y     <= add_out;
                acc   <= '0;
                sd[0] <= x;
                for (int k = 1; k < N; k++) begin
                    sd[k] <= sd[k-1];
                end
            end else begin
                p   <= p + PW'(1);
                acc <= add_out;
            end
        end
    end

endmodule

// File: tb/tb_fir_n_multicycle.sv
// Testbench for fir_n_multicycle: directed sequence with a frame-level
// scoreboard. Each captured sample pushes the expected next output into
// exp_q; the following frame end pops and compares it against y. Per-cycle
// debug taps are checked against an integer reference model of the taps.
module tb_fir_n_multicycle;

    localparam int W = 16;
    localparam int N = 2;
    localparam logic [N*W-1:0] COEFFS     = {16'h2AAA, 16'h2AAA};
    localparam logic [N*W-1:0] COEFFS_OVF = {16'h7FFF, 16'h7FFF};

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] x     = '0;
    logic [W-1:0] x_ovf = 16'h7FFF;
    logic [W-1:0] y, mul_show, add_show;
    logic [W-1:0] y_ovf, mul_ovf, add_ovf;

    fir_n_multicycle #(.WIDTH(W), .N(N), .COEFFS(COEFFS)) dut (
        .CLK(clk), .RST(rst), .x(x), .y(y),
        .mul_out_show(mul_show), .add_out_show(add_show)
    );

    fir_n_multicycle #(.WIDTH(W), .N(N), .COEFFS(COEFFS_OVF)) dut_ovf (
        .CLK(clk), .RST(rst), .x(x_ovf), .y(y_ovf),
        .mul_out_show(mul_ovf), .add_out_show(add_ovf)
    );

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_y;
    int mh [N];

    // Bring an integer back into W-bit range: clamp or wrap.
    function automatic int fit(input int v);
        logic [W-1:0] t;
`ifdef FIR_SATURATE_EN
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        t = v[W-1:0];
        return int'($signed(t));
`endif
    endfunction

    function automatic int coef(input int k);
        logic [N*W-1:0] cv;
        logic [W-1:0]   hk;
        cv = COEFFS;
        hk = cv[k*W +: W];
        return int'($signed(hk));
    endfunction

    function automatic int term(input int k);
        int prod;
        prod = coef(k) * mh[k];
        return fit(prod >>> (W - 1));
    endfunction

    function automatic int prefix(input int c);
        int s;
        s = 0;
        for (int k = 0; k <= c; k++) s = fit(s + term(k));
        return s;
    endfunction

    function automatic logic [W-1:0] to_w(input int v);
        return v[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int k = 0; k < N; k++) mh[k] = 0;
        last_y = '0;
        exp_q.push_back(to_w(prefix(N - 1)));
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------

    // Advances one edge first so reset lands mid-frame (p = 1) when called
    // at a frame boundary, then holds RST for two edges.
    task automatic do_reset();
        logic [W-1:0] pv;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pv = W'(dut.p);
        chk("reset_y",   y,        '0);
        chk("reset_mul", mul_show, '0);
        chk("reset_add", add_show, '0);
        chk("reset_p",   pv,       '0);
        model_reset();
    endtask

    // One frame: xo is driven during phases 0..N-2, xv during the last phase.
    task automatic frame(input logic [W-1:0] xv, input logic [W-1:0] xo);
        logic [W-1:0] e;
        for (int c = 0; c < N; c++) begin
            chk("mul_tap", mul_show, to_w(term(c)));
            chk("add_tap", add_show, to_w(prefix(c)));
            chk("y_hold",  y,        last_y);
            x = (c == N - 1) ? xv : xo;
            @(posedge clk); #1;
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL y_frame: observed %h expected <empty queue>", y);
        end else begin
            e = exp_q.pop_front();
            chk("y_frame", y, e);
            last_y = e;
        end
        for (int k = N - 1; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = int'($signed(xv));
        exp_q.push_back(to_w(prefix(N - 1)));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] rv, ro, y_ovf_exp;

        // Initial reset.
        do_reset();

        // Step response: hold 0.5.
        frame(16'h4000, 16'h4000);
        frame(16'h4000, 16'h4000);
        chk("step_y1", y, 16'h1555);
        chk("step_mul", mul_show, 16'h1555);
        frame(16'h4000, 16'h4000);
        chk("step_y2", y, 16'h2AAA);
        frame(16'h4000, 16'h4000);

        // Mid-frame reset with nonzero state, then hold -1.
        do_reset();
        frame(16'h8000, 16'h8000);
        frame(16'h8000, 16'h8000);
        chk("neg_y1", y, 16'hD556);
        chk("neg_mul", mul_show, 16'hD556);
        frame(16'h8000, 16'h8000);
        chk("neg_y2", y, 16'hAAAC);

        // Phase sensitivity: only the last-phase value of x is captured.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            frame(16'h0000, (i % 2 == 0) ? 16'h4000 : 16'h7FFF);
        end
        chk("phase_y", y, 16'h0000);

        // Debug taps with sd[0]=0x4000, sd[1]=0x2000.
        frame(16'h2000, 16'h0000);
        frame(16'h4000, 16'h0000);
        chk("dbg_mul_p0", mul_show, 16'h1555);
        chk("dbg_add_p0", add_show, 16'h1555);
        frame(16'h0000, 16'h0000);
        chk("dbg_y", y, 16'h1FFF);

        // Random samples against the model.
        for (int i = 0; i < 6; i++) begin
            rv = W'($urandom_range(0, 65535));
            ro = W'($urandom_range(0, 65535));
            frame(rv, ro);
        end
        frame(16'h0000, 16'h0000);
        frame(16'h0000, 16'h0000);

        // Overflow instance has held 0x7FFF since the last reset.
`ifdef FIR_SATURATE_EN
        y_ovf_exp = 16'h7FFF;
`else
        y_ovf_exp = 16'hFFFC;
`endif
        chk("ovf_mul", mul_ovf, 16'h7FFE);
        chk("ovf_add_p0", add_ovf, 16'h7FFE);
        chk("ovf_y", y_ovf, y_ovf_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
